dmem_lsu: RTL

Parametrised data memory for the MIPS datapath, replacing the word-indexed memory with combinational read.
- Takes byte addresses and supports byte, half and word loads and stores, with sign or zero extension on loads.
- Uses a valid/ready request channel and a response channel with a configurable, in-order read pipeline and backpressure.
- Flags misaligned and out-of-range accesses instead of aliasing them.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_fmt.sv | 34 +++
 rtl/dmem_lsu.sv | 76 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the byte-addressed data memory.
package dmem_pkg;
  localparam int DATAWIDTH = 32;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;
  typedef struct packed {
    logic valid;
    logic err;
    logic [DATAWIDTH-1:0] rdata;
  } rsp_t;
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: byte-lane formatting for stores and loads plus access error decode.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32
) (
  input  logic [1:0]           size,
  input  logic                 uns,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [DATAWIDTH-1:0] rword,
  output logic [3:0]           be,
  output logic [DATAWIDTH-1:0] wdata_sh,
  output logic [DATAWIDTH-1:0] rdata,
  output logic                 err
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [1:0] lane;
  logic oor;
  logic [DATAWIDTH-1:0] sh;
  always_comb begin
    lane = addr[1:0];
    oor = |(addr >> (IDX_W + 2));
    err = (size == 2'd3) || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && lane != 2'd0) || oor;
    be = size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    // replicated data lands on every lane; the byte enables pick the right one
    wdata_sh = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    sh = rword >> {lane, 3'b000};
    rdata = err ? '0 :
            size == SZ_BYTE ? {{24{sh[7] & ~uns}}, sh[7:0]} :
            size == SZ_HALF ? {{16{sh[15] & ~uns}}, sh[15:0]} : rword;
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed data memory with valid/ready request and pipelined in-order response.
// Defining DMEM_ERR_COUNT_EN adds a saturating 16-bit err_cnt output.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int READ_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err
`ifdef DMEM_ERR_COUNT_EN
  ,
  output logic [15:0]          err_cnt
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  logic [DATAWIDTH-1:0] mem [DEPTH];
  rsp_t stg [READ_LAT];
  rsp_t nxt;
  logic stall, acc, err;
  logic [IDX_W-1:0] idx;
  logic [3:0] be;
  logic [DATAWIDTH-1:0] wdata_sh, ld_data;
  assign rsp_valid = stg[READ_LAT-1].valid;
  assign rsp_err = stg[READ_LAT-1].err;
  assign rsp_rdata = stg[READ_LAT-1].rdata;
  assign stall = rsp_valid && !rsp_ready;
  assign req_ready = rst_n && !stall;
  assign acc = req_valid && req_ready;
  assign idx = req_addr[2 +: IDX_W];
  dmem_lane_fmt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fmt (
    .size(req_size),
    .uns(req_unsigned),
    .addr(req_addr),
    .wdata(req_wdata),
    .rword(mem[idx]),
    .be(be),
    .wdata_sh(wdata_sh),
    .rdata(ld_data),
    .err(err)
  );
  always_comb begin
    nxt.valid = acc;
    nxt.err = acc && err;
    nxt.rdata = acc && !req_we ? ld_data : '0;
  end
  // acc already includes rst_n, so the unreset array needs no reset term
  always_ff @(posedge clk)
    if (acc && req_we && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= nxt;
      for (int i = 1; i < READ_LAT; i++) stg[i] <= stg[i-1];
    end
`ifdef DMEM_ERR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (acc && err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`endif
endmodule
